// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU sizing, sequencer FSM encoding and timer preload helper
package mmu_pkg;
   localparam int SIZE      = 4;
   localparam int BIT_WIDTH = 8;
   localparam int ARR_WIDTH = SIZE * BIT_WIDTH;
   localparam int ACC_WIDTH = SIZE * SIZE * 16;
   localparam int WT_SETTLE = 8;
   localparam int DRAIN_CYC = 8;
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_SETTLE,
      S_STREAM,
      S_DRAIN,
      S_RESULT
   } state_t;

   // DRAIN loads DRAIN_CYC rather than DRAIN_CYC-1 so its final zero cycle is the capture cycle
   function automatic logic [CNT_W-1:0] tmr_init(state_t s);
      return (s == S_LOAD_W) ? CNT_W'(SIZE - 1) :
             (s == S_SETTLE) ? CNT_W'(WT_SETTLE - 1) :
             (s == S_DRAIN)  ? CNT_W'(DRAIN_CYC) : '0;
   endfunction
endpackage

// File: rtl/mmu_seq_timer.sv
// mmu_seq_timer: loadable down-counter that parks at zero and flags it
module mmu_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;

   // load takes priority; otherwise count down and hold at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl: weight preload, activation streaming and result capture for the 4x4 MMU
module mmu_seq_ctrl
   import mmu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [CNT_W-1:0]     i_num_vec,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   input  logic                 i_wt_valid,
   input  logic [ARR_WIDTH-1:0] i_wt_data,
   output logic                 o_wt_ready,
   input  logic                 i_act_valid,
   input  logic [ARR_WIDTH-1:0] i_act_data,
   output logic                 o_act_ready,
   output logic                 o_mmu_control,
   output logic [ARR_WIDTH-1:0] o_mmu_wt_arr,
   output logic [ARR_WIDTH-1:0] o_mmu_data_arr,
   input  logic [ACC_WIDTH-1:0] i_mmu_acc_out,
   output logic                 o_res_valid,
   output logic [ACC_WIDTH-1:0] o_res_data,
   input  logic                 i_res_ready
);
   state_t               r_state, w_nxt;
   logic [CNT_W-1:0]     r_num, r_vcnt;
   logic                 r_err, r_mmu_ctrl;
   logic [ARR_WIDTH-1:0] r_wt_arr, r_data_arr;
   logic [ACC_WIDTH-1:0] r_res_data;
   logic                 w_wt_beat, w_act_beat, w_last_vec, w_tmr_ld, w_tmr_zero;
   logic [CNT_W-1:0]     w_tmr_val;

   assign w_wt_beat  = (r_state == S_LOAD_W) && i_wt_valid;
   assign w_act_beat = (r_state == S_STREAM) && i_act_valid;
   assign w_last_vec = w_act_beat && (r_vcnt == r_num - CNT_W'(1));

   // one timer serves LOAD_W, SETTLE and DRAIN; it is reloaded on every state change
   mmu_seq_timer #(.W(CNT_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_tmr_ld),
      .i_val  (w_tmr_val),
      .o_zero (w_tmr_zero)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_nxt;
   end

   // next-state decode and timer preload
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:   w_nxt = i_start ? S_LOAD_W : S_IDLE;
         S_LOAD_W: w_nxt = !i_wt_valid ? S_IDLE : w_tmr_zero ? S_SETTLE : S_LOAD_W;
         S_SETTLE: w_nxt = !w_tmr_zero ? S_SETTLE : (r_num == '0) ? S_DRAIN : S_STREAM;
         S_STREAM: w_nxt = w_last_vec ? S_DRAIN : S_STREAM;
         S_DRAIN:  w_nxt = w_tmr_zero ? S_RESULT : S_DRAIN;
         S_RESULT: w_nxt = i_res_ready ? S_IDLE : S_RESULT;
         default:  w_nxt = S_IDLE;
      endcase
      w_tmr_ld  = (w_nxt != r_state);
      w_tmr_val = tmr_init(w_nxt);
   end

   // registered MMU drive, job bookkeeping and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num      <= '0;
         r_vcnt     <= '0;
         r_err      <= 1'b0;
         r_mmu_ctrl <= 1'b0;
         r_wt_arr   <= '0;
         r_data_arr <= '0;
         r_res_data <= '0;
      end else begin
         r_mmu_ctrl <= w_wt_beat;
         r_wt_arr   <= w_wt_beat ? i_wt_data : '0;
         r_data_arr <= w_act_beat ? i_act_data : '0;
         if (r_state == S_IDLE && i_start) begin
            r_num  <= i_num_vec;
            r_vcnt <= '0;
            r_err  <= 1'b0;
         end
         if (r_state == S_LOAD_W && !i_wt_valid) r_err <= 1'b1;
         if (w_act_beat) r_vcnt <= r_vcnt + CNT_W'(1);
         if (r_state == S_DRAIN && w_tmr_zero) r_res_data <= i_mmu_acc_out;
      end
   end

   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = (r_state == S_RESULT) && i_res_ready;
   assign o_err          = r_err;
   assign o_wt_ready     = (r_state == S_LOAD_W);
   assign o_act_ready    = (r_state == S_STREAM);
   assign o_res_valid    = (r_state == S_RESULT);
   assign o_mmu_control  = r_mmu_ctrl;
   assign o_mmu_wt_arr   = r_wt_arr;
   assign o_mmu_data_arr = r_data_arr;
   assign o_res_data     = r_res_data;
endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// tb_mmu_seq_ctrl: directed checks of the MMU sequencer against a behavioural MMU
module tb_mmu_seq_ctrl;
   import mmu_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_start, i_wt_valid, i_act_valid, i_res_ready;
   logic [CNT_W-1:0]     i_num_vec;
   logic [ARR_WIDTH-1:0] i_wt_data, i_act_data;
   logic [ACC_WIDTH-1:0] i_mmu_acc_out;
   logic                 o_busy, o_done, o_err, o_wt_ready, o_act_ready, o_mmu_control, o_res_valid;
   logic [ARR_WIDTH-1:0] o_mmu_wt_arr, o_mmu_data_arr;
   logic [ACC_WIDTH-1:0] o_res_data;

   mmu_seq_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .i_num_vec      (i_num_vec),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_err          (o_err),
      .i_wt_valid     (i_wt_valid),
      .i_wt_data      (i_wt_data),
      .o_wt_ready     (o_wt_ready),
      .i_act_valid    (i_act_valid),
      .i_act_data     (i_act_data),
      .o_act_ready    (o_act_ready),
      .o_mmu_control  (o_mmu_control),
      .o_mmu_wt_arr   (o_mmu_wt_arr),
      .o_mmu_data_arr (o_mmu_data_arr),
      .i_mmu_acc_out  (i_mmu_acc_out),
      .o_res_valid    (o_res_valid),
      .o_res_data     (o_res_data),
      .i_res_ready    (i_res_ready)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          n_hs  = 0;
   logic        seen_ar = 1'b0;
   logic [31:0] rows [4] = '{32'h0100_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0001};

   // behavioural MMU: column c accumulates sum over rows of act[r] * w[r][c]
   logic [7:0]  mw   [4][4];
   logic [15:0] mcol [4];
   int          mrow;

   // model update on the registered MMU drive; a fresh weight tile clears the accumulators
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mrow = 0;
         for (int r = 0; r < 4; r++) begin
            mcol[r] = '0;
            for (int c = 0; c < 4; c++) mw[r][c] = '0;
         end
      end else begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               mcol[c] = mcol[c] + 16'(o_mmu_data_arr[8*r +: 8]) * 16'(mw[r][c]);
         if (o_mmu_control) begin
            if (mrow == 0) for (int c = 0; c < 4; c++) mcol[c] = '0;
            for (int c = 0; c < 4; c++) mw[mrow][c] = o_mmu_wt_arr[8*(3-c) +: 8];
            mrow = (mrow + 1) % 4;
         end else begin
            mrow = 0;
         end
      end
   end

   assign i_mmu_acc_out = {192'b0, mcol[3], mcol[2], mcol[1], mcol[0]};

   // handshake and act_ready observers
   always @(posedge clk) begin
      if (i_act_valid && o_act_ready) n_hs++;
      if (o_act_ready) seen_ar = 1'b1;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // start a job and feed weight rows; beat 'bad' is withheld (4 = no underrun)
   task automatic start_job(input logic [7:0] n, input int bad);
      cyc       = 0;
      i_start   = 1'b1;
      i_num_vec = n;
      tick();
      i_start   = 1'b0;
      check("err_clr", o_err, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("wt_ready", o_wt_ready, 1'b1);
         if (k == bad) begin
            i_wt_valid = 1'b0;
            tick();
            return;
         end
         i_wt_valid = 1'b1;
         i_wt_data  = rows[k];
         tick();
         check("mmu_ctrl", o_mmu_control, 1'b1);
         check("mmu_wt", o_mmu_wt_arr, rows[k]);
      end
      i_wt_valid = 1'b0;
      i_wt_data  = '0;
   endtask

   task automatic wait_res(input int exp_cyc);
      while (!o_res_valid && cyc < 1000) tick();
      check("latency", cyc, exp_cyc);
   endtask

   task automatic take_res;
      i_res_ready = 1'b1;
      #1;
      check("done_hs", o_done, 1'b1);
      tick();
      i_res_ready = 1'b0;
      #1;
      check("done_pulse", o_done, 1'b0);
      check("idle_after", o_busy, 1'b0);
   endtask

   logic       bad;
   logic [5:0] pat;

   initial begin
      rst_n       = 1'b0;
      i_start     = 1'b0;
      i_num_vec   = '0;
      i_wt_valid  = 1'b0;
      i_wt_data   = '0;
      i_act_valid = 1'b0;
      i_act_data  = '0;
      i_res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {o_busy, o_done, o_err, o_wt_ready, o_act_ready, o_mmu_control, o_res_valid}, 7'b0);
      check("rst_arr", {o_mmu_wt_arr, o_mmu_data_arr}, 64'b0);
      check("rst_res", o_res_data, 256'b0);
      rst_n = 1'b1;
      tick();

      // identity weights, four vectors back to back
      i_act_valid = 1'b1;
      i_act_data  = 32'h0403_0201;
      n_hs        = 0;
      start_job(8'd4, 4);
      wait_res(26);
      i_act_valid = 1'b0;
      check("t1_cols", o_res_data, {192'b0, 64'h0010_000c_0008_0004});
      check("t1_hs", n_hs, 4);
      take_res();

      // bubbles in the activation stream
      n_hs = 0;
      start_job(8'd4, 4);
      while (!o_act_ready && cyc < 100) tick();
      check("t2_stream_at", cyc, 13);
      pat = 6'b110101;
      for (int i = 0; i < 6; i++) begin
         i_act_valid = pat[i];
         tick();
         if (!pat[i]) check("t2_bubble_zero", o_mmu_data_arr, 32'h0);
      end
      i_act_valid = 1'b0;
      check("t2_ready_drop", o_act_ready, 1'b0);
      check("t2_hs", n_hs, 4);
      wait_res(28);
      check("t2_cols", o_res_data, {192'b0, 64'h0010_000c_0008_0004});
      take_res();

      // weight underrun on the third beat
      start_job(8'd4, 2);
      check("t3_err", o_err, 1'b1);
      check("t3_idle", o_busy, 1'b0);
      check("t3_ctrl_off", o_mmu_control, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         bad = bad | o_res_valid | o_busy;
      end
      check("t3_no_result", bad, 1'b0);
      check("t3_err_sticky", o_err, 1'b1);

      // zero vectors: no streaming at all
      seen_ar = 1'b0;
      start_job(8'd0, 4);
      wait_res(22);
      check("t4_no_act_ready", seen_ar, 1'b0);
      check("t4_cols", o_res_data, 256'b0);
      take_res();

      // result back-pressure with start pulses
      i_act_valid = 1'b1;
      start_job(8'd1, 4);
      wait_res(23);
      i_act_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         i_start   = (i % 2 == 0);
         i_num_vec = 8'd5;
         tick();
         bad = bad | o_done | !o_res_valid | (o_res_data !== {192'b0, 64'h0004_0003_0002_0001});
      end
      i_start = 1'b0;
      check("t5_hold", bad, 1'b0);
      check("t5_cols", o_res_data, {192'b0, 64'h0004_0003_0002_0001});
      take_res();

      // reset in the middle of streaming, then a clean job
      i_act_valid = 1'b1;
      i_act_data  = 32'h0403_0201;
      start_job(8'd4, 4);
      while (!o_act_ready && cyc < 100) tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_ctl", {o_busy, o_done, o_err, o_wt_ready, o_act_ready, o_mmu_control, o_res_valid}, 7'b0);
      check("t6_rst_arr", {o_mmu_wt_arr, o_mmu_data_arr}, 64'b0);
      check("t6_rst_res", o_res_data, 256'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("t6_no_result", o_res_valid, 1'b0);
      n_hs = 0;
      start_job(8'd4, 4);
      wait_res(26);
      check("t6_cols", o_res_data, {192'b0, 64'h0010_000c_0008_0004});
      check("t6_hs", n_hs, 4);
      i_act_valid = 1'b0;
      take_res();

      // maximum vector count must not wrap
      i_act_valid = 1'b1;
      i_act_data  = 32'h0101_0101;
      n_hs        = 0;
      start_job(8'd255, 4);
      wait_res(277);
      i_act_valid = 1'b0;
      check("max_cols", o_res_data, {192'b0, 64'h00ff_00ff_00ff_00ff});
      check("max_hs", n_hs, 255);
      take_res();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
